sw_debounce: RTL and testbench

- Input conditioner for the board switch bank, placed directly upstream of the core's i_io_sw port.
- Synchronises each raw switch bit into the i_clk domain and debounces it with a per-bit stability counter.
- Presents a clean registered switch word to the core.
- Emits a one-cycle change pulse plus a mask of the toggled bits, usable by the input driver or an interrupt source.

---
 rtl/sw_debounce.sv | 50 +++++
 tb/tb_sw_debounce.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch synchroniser + stability-counter debouncer with change pulse; SW_DEBOUNCE_BYPASS_EN drops the counters
module sw_debounce #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_sw_raw,
    output logic [WIDTH-1:0] o_io_sw,
    output logic             o_sw_change,
    output logic [WIDTH-1:0] o_sw_changed_mask
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] done;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk)
        if (!i_reset) sync_q <= '{default: '0};
        else begin
            sync_q[0] <= i_sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end

`ifdef SW_DEBOUNCE_BYPASS_EN
    assign done = sync ^ o_io_sw;
`else
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [CW-1:0] cnt;
        assign done[b] = (sync[b] != o_io_sw[b]) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
        // any match drops a partial count, so a bouncing input never accumulates
        always_ff @(posedge i_clk)
            cnt <= (!i_reset || sync[b] == o_io_sw[b] || done[b]) ? '0 : cnt + CW'(1);
    end
`endif

    always_ff @(posedge i_clk)
        if (!i_reset) begin
            o_io_sw           <= '0;
            o_sw_change       <= 1'b0;
            o_sw_changed_mask <= '0;
        end else begin
            o_io_sw           <= o_io_sw ^ done;
            o_sw_change       <= |done;
            o_sw_changed_mask <= done;
        end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: randomized + directed bench against a sliding-window reference model
module tb_sw_debounce;
    localparam int W  = 32;
    localparam int SS = 2;
    localparam int DC = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw = '1;
    logic [W-1:0] io_sw;
    logic         chg;
    logic [W-1:0] mask;

    int n_checks = 0;
    int n_fail = 0;
    int pulses = 0;
    int p0;

    logic [W-1:0] m_pipe [SS];
    logic [W-1:0] m_hist [$];
    logic [W-1:0] m_o = '0, m_mask = '0, all1, all0, t;
    logic         m_chg = 1'b0;

    sw_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_sw_raw(raw),
        .o_io_sw(io_sw),
        .o_sw_change(chg),
        .o_sw_changed_mask(mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A bit flips once the last DC synchronised samples all disagree with it
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pipe = '{default: '0};
            m_hist.delete();
            m_o = '0;
            m_chg = 1'b0;
            m_mask = '0;
        end else begin
            m_hist.push_back(m_pipe[SS-1]);
            if (m_hist.size() > DC) void'(m_hist.pop_front());
            all1 = '1;
            all0 = '1;
            foreach (m_hist[i]) begin
                all1 &= m_hist[i];
                all0 &= ~m_hist[i];
            end
            t = (m_hist.size() == DC) ? ((all1 & ~m_o) | (all0 & m_o)) : '0;
            m_mask = t;
            m_chg = |t;
            m_o ^= t;
            for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
            m_pipe[0] = raw;
        end
    end

    always @(negedge clk) begin
        check("io_sw", io_sw, m_o);
        check("change", {31'b0, chg}, {31'b0, m_chg});
        check("mask", mask, m_mask);
        if (chg) pulses++;
    end

    initial begin
        m_pipe = '{default: '0};
        tick(10);
        check("reset_io_sw", io_sw, '0);
        check("reset_change", {31'b0, chg}, '0);
        rst_n = 1'b1;
        raw = '0;
        tick(20);
        // clean step: edge 0 is the edge just passed
        p0 = pulses;
        raw = 32'h0000_00A5;
        tick(17);
        check("step_pre", io_sw, '0);
        tick(1);
        check("step_post", io_sw, 32'h0000_00A5);
        check("step_mask", mask, 32'h0000_00A5);
        check("step_change", {31'b0, chg}, 32'h1);
        tick(1);
        check("step_change_drop", {31'b0, chg}, '0);
        check("step_pulses", pulses - p0, 1);
        raw = '0;
        tick(20);
        // glitch of DC-6 cycles
        p0 = pulses;
        raw = 32'h1;
        tick(10);
        raw = '0;
        tick(20);
        check("glitch_io_sw", io_sw, '0);
        check("glitch_pulses", pulses - p0, 0);
        // bounce on bit3
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            raw ^= 32'h8;
            tick(3);
        end
        raw = 32'h8;
        tick(17);
        check("bounce_pre", io_sw, '0);
        tick(1);
        check("bounce_post", io_sw, 32'h8);
        check("bounce_mask", mask, 32'h8);
        tick(2);
        check("bounce_pulses", pulses - p0, 1);
        raw = '0;
        tick(20);
        // reset mid-debounce
        raw = 32'h1;
        tick(10);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        p0 = pulses;
        tick(17);
        check("rst_mid_pre", io_sw, '0);
        tick(1);
        check("rst_mid_post", io_sw, 32'h1);
        check("rst_mid_mask", mask, 32'h1);
        tick(2);
        check("rst_mid_pulses", pulses - p0, 1);
        raw = '0;
        tick(20);
        // independent bits
        raw = 32'h1;
        tick(5);
        raw = 32'h3;
        tick(13);
        check("indep_a", io_sw, 32'h1);
        check("indep_a_mask", mask, 32'h1);
        tick(5);
        check("indep_b", io_sw, 32'h3);
        check("indep_b_mask", mask, 32'h2);
        // random phase, model-checked every cycle
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            raw ^= ($urandom_range(0, 3) == 0) ? W'($urandom) : (W'(1) << $urandom_range(0, W - 1));
            tick($urandom_range(1, 24));
        end
        tick(25);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
